// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter: byte width, default guard gap
// and the arbiter state encoding.
package uart_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEF_GAP_TICKS = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_SEND      = 2'd1;
  localparam state_t ST_WAIT_DONE = 2'd2;
  localparam state_t ST_GAP       = 2'd3;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request bit scanning upward from
// i_ptr with wrap-around.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_any
);

  int               w_idx;
  logic [IDX_W-1:0] w_cand;

  assign o_any = |i_req;

  // Scan from farthest to nearest so the candidate closest to i_ptr wins last.
  always_comb begin
    o_winner = '0;
    w_idx    = 0;
    w_cand   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      w_cand = IDX_W'(w_idx);
      if (i_req[w_cand]) begin
        o_winner = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte-stream
// requesters; a grant is held for a whole frame and followed by an idle guard gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = 2,
  parameter int GAP_TICKS = DEF_GAP_TICKS
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_tick,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [BYTE_W*NUM_REQ-1:0] i_data,
  input  logic [NUM_REQ-1:0]        i_last,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [IDX_W-1:0]          o_grant_id,
  output logic                      o_busy,
  output logic                      o_tx_start,
  output logic [BYTE_W-1:0]         o_tx_data,
  input  logic                      i_tx_done
);

  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_TICKS > 0) ? GAP_W'(GAP_TICKS - 1) : '0;

  state_t              r_state;
  logic [IDX_W-1:0]    r_grant_id;
  logic [IDX_W-1:0]    r_ptr;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic                r_gap_armed;
  logic                r_frame_end;
  logic [NUM_REQ-1:0]  r_ack;
  logic                r_tx_start;
  logic [BYTE_W-1:0]   r_tx_data;

  logic [IDX_W-1:0]    w_winner;
  logic                w_any_req;
  logic [IDX_W-1:0]    w_next_ptr;
  logic [NUM_REQ-1:0]  w_grant_onehot;
  logic [BYTE_W-1:0]   w_grant_data;
  logic                w_tick_counted;
  logic                w_gap_done;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any_req)
  );

  assign w_next_ptr     = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + IDX_W'(1);
  assign w_grant_onehot = NUM_REQ'(1) << r_grant_id;
  assign w_grant_data   = i_data[r_grant_id*BYTE_W +: BYTE_W];

  // The first GAP cycle is unarmed, so a tick landing on entry is not counted.
  assign w_tick_counted = i_tick && r_gap_armed;
  assign w_gap_done     = (GAP_TICKS == 0) || (w_tick_counted && (r_gap_cnt >= GAP_LAST));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_grant_id  <= '0;
      r_ptr       <= '0;
      r_gap_cnt   <= '0;
      r_gap_armed <= 1'b0;
      r_frame_end <= 1'b0;
      r_ack       <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_grant_id <= w_winner;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (i_req[r_grant_id]) begin
            r_tx_start  <= 1'b1;
            r_ack       <= w_grant_onehot;
            r_tx_data   <= w_grant_data;
            r_frame_end <= i_last[r_grant_id];
            r_state     <= ST_WAIT_DONE;
          end else begin
            r_gap_cnt   <= '0;
            r_gap_armed <= 1'b0;
            r_state     <= ST_GAP;
          end
        end
        ST_WAIT_DONE: begin
          if (i_tx_done) begin
            if (r_frame_end) begin
              r_gap_cnt   <= '0;
              r_gap_armed <= 1'b0;
              r_state     <= ST_GAP;
            end else begin
              r_state <= ST_SEND;
            end
          end
        end
        ST_GAP: begin
          r_gap_armed <= 1'b1;
          if (w_gap_done) begin
            r_ptr   <= w_next_ptr;
            r_state <= ST_IDLE;
          end else if (w_tick_counted) begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ack      = r_ack;
  assign o_grant_id = r_grant_id;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with a 16-tick gap and one
// with no gap, driven by queued requester frames and a simple transmitter model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tickAuto = 1'b0;
  logic        tickManual = 1'b0;
  logic        tick;
  logic        tickEnable = 1'b1;
  int          tickPeriod = 434;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  last;
  logic        txDone = 1'b0;
  logic [3:0]  ack;
  logic [1:0]  grantId;
  logic        busy;
  logic        txStart;
  logic [7:0]  txData;

  logic [3:0]  zReq = '0;
  logic [31:0] zData = '0;
  logic [3:0]  zLast = '0;
  logic        zTxDone = 1'b0;
  logic [3:0]  zAck;
  logic [1:0]  zGrantId;
  logic        zBusy;
  logic        zTxStart;
  logic [7:0]  zTxData;

  int          assertCount = 0;
  int          failCount = 0;
  int          cycleCount = 0;
  logic [8:0]  reqQ[NUM_REQ][$];
  logic [7:0]  evData[$];
  logic [1:0]  evGrant[$];
  int          evCycle[$];

  assign tick = tickAuto | tickManual;

  uart_tx_arbiter #(.NUM_REQ(4), .IDX_W(2), .GAP_TICKS(16)) dut (
    .i_clock(clock), .i_reset(reset), .i_tick(tick), .i_req(req), .i_data(data),
    .i_last(last), .o_ack(ack), .o_grant_id(grantId), .o_busy(busy),
    .o_tx_start(txStart), .o_tx_data(txData), .i_tx_done(txDone)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .IDX_W(2), .GAP_TICKS(0)) dutNoGap (
    .i_clock(clock), .i_reset(reset), .i_tick(tick), .i_req(zReq), .i_data(zData),
    .i_last(zLast), .o_ack(zAck), .o_grant_id(zGrantId), .o_busy(zBusy),
    .o_tx_start(zTxStart), .o_tx_data(zTxData), .i_tx_done(zTxDone)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [7:0] value, input logic isLast);
    reqQ[id].push_back({isLast, value});
  endtask

  task automatic clearLog();
    evData.delete();
    evGrant.delete();
    evCycle.delete();
  endtask

  task automatic waitEvents(input string tag, input int count, input int budget);
    int n = 0;
    while (evData.size() < count && n < budget) begin
      @(posedge clock); #1; n++;
    end
    checkOutput(tag, 32'(evData.size()), 32'(count));
  endtask

  task automatic waitIdle(input string tag, input int budget, output int waited);
    int n = 0;
    do begin
      @(posedge clock); #1; n++;
    end while (busy && n < budget);
    waited = n;
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  // Requesters: present the head of their queue, pop it once acked.
  initial begin
    req = '0; data = '0; last = '0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ack[i] && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
        if (reqQ[i].size() > 0) begin
          req[i] = 1'b1; data[8*i +: 8] = reqQ[i][0][7:0]; last[i] = reqQ[i][0][8];
        end else begin
          req[i] = 1'b0; data[8*i +: 8] = 8'h00; last[i] = 1'b0;
        end
      end
    end
  end

  // Transmitter model: tx_done ten cycles after each tx_start.
  initial begin
    forever begin
      @(negedge clock);
      if (txStart) begin
        repeat (10) @(negedge clock);
        txDone = 1'b1;
        @(negedge clock);
        txDone = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      repeat (tickPeriod - 1) @(negedge clock);
      tickAuto = tickEnable;
      @(negedge clock);
      tickAuto = 1'b0;
    end
  end

  // Every transfer: ack must be one-hot on the grant holder and coincide with tx_start.
  always @(negedge clock) begin
    if (!reset && (txStart || ack != '0)) begin
      checkOutput("ackWithStart", 32'({txStart, ack}), 32'({1'b1, 4'(4'b1 << grantId)}));
      evData.push_back(txData);
      evGrant.push_back(grantId);
      evCycle.push_back(cycleCount);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int ticks;
    int reqCycle;
    int t1;
    int t2;

    #2 reset = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstAck", 32'(ack), 32'd0);
    checkOutput("rstStart", 32'(txStart), 32'd0);
    checkOutput("rstData", 32'(txData), 32'd0);
    checkOutput("rstGrant", 32'(grantId), 32'd0);
    checkOutput("rstNoGapBusy", 32'(zBusy), 32'd0);
    reset = 1'b0;

    $display("[TB] single frame on requester 2");
    @(posedge clock); #1;
    clearLog();
    applyStimulus(2, 8'h11, 1'b0);
    applyStimulus(2, 8'h22, 1'b0);
    applyStimulus(2, 8'h33, 1'b1);
    reqCycle = cycleCount;
    n = 0;
    while (!(evData.size() == 3 && txDone) && n < 20000) begin
      @(posedge clock); #1; n++;
    end
    checkOutput("t1LastDone", 32'(n < 20000), 32'd1);
    @(posedge clock); #1;
    ticks = 0; n = 0;
    do begin
      @(posedge clock); #1; n++;
      if (tick) ticks++;
    end while (busy && n < 10000);
    checkOutput("t1GapTicks", 32'(ticks), 32'd16);
    checkOutput("t1BusyLow", 32'(busy), 32'd0);
    checkOutput("t1Count", 32'(evData.size()), 32'd3);
    if (evData.size() == 3) begin
      checkOutput("t1Latency", 32'(evCycle[0] - reqCycle), 32'd2);
      checkOutput("t1Byte0", 32'(evData[0]), 32'h11);
      checkOutput("t1Byte1", 32'(evData[1]), 32'h22);
      checkOutput("t1Byte2", 32'(evData[2]), 32'h33);
      checkOutput("t1Grant", 32'({evGrant[0], evGrant[1], evGrant[2]}), 32'({2'd2, 2'd2, 2'd2}));
      checkOutput("t1NextByte", 32'(evCycle[1] - evCycle[0]), 32'd12);
    end
    checkOutput("t1GrantHeld", 32'(grantId), 32'd2);

    $display("[TB] contention between requesters 0 and 3");
    tickPeriod = 4;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    clearLog();
    applyStimulus(0, 8'hA0, 1'b1);
    applyStimulus(3, 8'hA3, 1'b1);
    waitEvents("t2First", 2, 2000);
    waitIdle("t2Idle", 2000, n);
    applyStimulus(0, 8'hB0, 1'b1);
    applyStimulus(3, 8'hB3, 1'b1);
    waitEvents("t2Second", 4, 2000);
    waitIdle("t2Idle2", 2000, n);
    if (evData.size() == 4) begin
      checkOutput("t2Order", 32'({evGrant[0], evGrant[1], evGrant[2], evGrant[3]}),
                  32'({2'd0, 2'd3, 2'd0, 2'd3}));
      checkOutput("t2Data", 32'({evData[0], evData[1], evData[2], evData[3]}), 32'hA0A3B0B3);
    end

    $display("[TB] frame lock on requester 1");
    clearLog();
    applyStimulus(1, 8'h51, 1'b0);
    applyStimulus(1, 8'h52, 1'b1);
    waitEvents("t3FirstByte", 1, 2000);
    applyStimulus(0, 8'h60, 1'b1);
    waitEvents("t3All", 3, 2000);
    waitIdle("t3Idle", 2000, n);
    if (evData.size() == 3) begin
      checkOutput("t3Order", 32'({evGrant[0], evGrant[1], evGrant[2]}), 32'({2'd1, 2'd1, 2'd0}));
      checkOutput("t3Data", 32'({evData[0], evData[1], evData[2]}), 32'h515260);
    end

    $display("[TB] requester 1 drops mid-frame");
    clearLog();
    applyStimulus(1, 8'h71, 1'b0);
    applyStimulus(1, 8'h72, 1'b1);
    waitEvents("t4FirstByte", 1, 2000);
    reqQ[1].delete();
    waitIdle("t4Idle", 2000, n);
    checkOutput("t4GapHeld", 32'(n > 40), 32'd1);
    repeat (20) @(posedge clock);
    #1;
    checkOutput("t4NoSecond", 32'(evData.size()), 32'd1);
    if (evData.size() >= 1) checkOutput("t4Byte", 32'(evData[0]), 32'h71);

    $display("[TB] reset during WAIT_DONE");
    clearLog();
    applyStimulus(2, 8'h81, 1'b0);
    applyStimulus(2, 8'h82, 1'b1);
    waitEvents("t5FirstByte", 1, 2000);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    reqQ[2].delete();
    #1;
    checkOutput("t5RstBusy", 32'(busy), 32'd0);
    checkOutput("t5RstData", 32'(txData), 32'd0);
    checkOutput("t5RstGrant", 32'(grantId), 32'd0);
    checkOutput("t5RstPulses", 32'({txStart, ack}), 32'd0);
    @(negedge clock); reset = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    checkOutput("t5IgnoredDone", 32'({busy, 4'(evData.size())}), 32'({1'b0, 4'd1}));
    applyStimulus(0, 8'h90, 1'b1);
    waitEvents("t5Served", 2, 2000);
    waitIdle("t5Idle", 2000, n);
    if (evData.size() == 2) checkOutput("t5Byte", 32'({evGrant[1], evData[1]}), 32'({2'd0, 8'h90}));

    $display("[TB] tick on the first GAP cycle is not counted");
    tickEnable = 1'b0;
    @(posedge clock); #1;
    applyStimulus(3, 8'hC3, 1'b1);
    n = 0;
    do begin
      @(negedge clock); n++;
    end while (!txStart && n < 200);
    checkOutput("t7Start", 32'(txStart), 32'd1);
    repeat (11) @(negedge clock);
    tickManual = 1'b1;
    @(negedge clock); tickManual = 1'b0;
    checkOutput("t7InGap", 32'(busy), 32'd1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clock); tickManual = 1'b1;
      @(negedge clock); tickManual = 1'b0;
    end
    repeat (2) @(negedge clock);
    checkOutput("t7After15", 32'(busy), 32'd1);
    @(negedge clock); tickManual = 1'b1;
    @(negedge clock); tickManual = 1'b0;
    checkOutput("t7After16", 32'(busy), 32'd0);

    $display("[TB] zero-gap instance back-to-back frames");
    @(negedge clock);
    zReq = 4'b0110; zData = {8'h00, 8'hE2, 8'hE1, 8'h00}; zLast = 4'b0110;
    n = 0;
    do begin
      @(negedge clock); n++;
    end while (!zTxStart && n < 100);
    t1 = cycleCount;
    checkOutput("t6First", 32'({zTxStart, zAck, zGrantId, zTxData}), 32'({1'b1, 4'b0010, 2'd1, 8'hE1}));
    zReq = 4'b0100;
    @(negedge clock); zTxDone = 1'b1;
    @(negedge clock); zTxDone = 1'b0; tickManual = 1'b1;
    @(negedge clock); tickManual = 1'b0;
    n = 0;
    do begin
      @(negedge clock); n++;
    end while (!zTxStart && n < 100);
    t2 = cycleCount;
    checkOutput("t6Second", 32'({zTxStart, zAck, zGrantId, zTxData}), 32'({1'b1, 4'b0100, 2'd2, 8'hE2}));
    checkOutput("t6Spacing", 32'(t2 - t1), 32'd5);
    zReq = 4'b0000;
    @(negedge clock); zTxDone = 1'b1;
    @(negedge clock); zTxDone = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("t6Idle", 32'(zBusy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
